// File: rtl/sipo_pack.sv
// Serial-in/parallel-out packer: PE_NUM complex words per bus word; full word emits on the accepting edge.
// Output register plus assembly buffer absorb 2*PE_NUM words under backpressure; flush emits a zero-padded partial.
module sipo_pack #(
   parameter int PE_NUM     = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             s_in_v,
   input  logic [2*DATA_WIDTH-1:0]          s_in,
   output logic                             s_in_rdy,
   input  logic                             flush,
   output logic                             p_out_v,
   output logic [PE_NUM*2*DATA_WIDTH-1:0]   p_out,
   output logic [$clog2(PE_NUM):0]          p_out_len,
   input  logic                             p_out_rdy
);

   localparam int WW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(PE_NUM) + 1;

   typedef logic [CW-1:0]                 cnt_t;
   typedef logic [PE_NUM-1:0][WW-1:0]     lanes_t;

   lanes_t asm_q;
   lanes_t asm_d;
   cnt_t   cnt_q;
   cnt_t   cnt_d;
   logic   pend_q;
   logic   pend_d;
   logic   run_q;
   logic   acc;
   logic   slot_free;
   logic   emit;

   // run_q keeps s_in_rdy low until the first edge after reset release
   assign s_in_rdy  = rst_n && run_q && (cnt_q < cnt_t'(PE_NUM)) && !pend_q;
   assign acc       = s_in_v && s_in_rdy;
   assign slot_free = !p_out_v || p_out_rdy;

   always_comb begin
      asm_d = asm_q;
      cnt_d = cnt_q;
      if (acc) begin
         asm_d[cnt_q[CW-2:0]] = s_in;
         cnt_d                = cnt_q + cnt_t'(1);
      end
      // a flush that lands exactly on word completion is redundant: the full word goes out anyway
      pend_d = pend_q || (flush && (cnt_d != cnt_t'(0)) && (cnt_d != cnt_t'(PE_NUM)));
      // only a registered flush request emits, so a partial never leaves on its own flush edge
      emit   = slot_free && ((cnt_d == cnt_t'(PE_NUM)) || pend_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         asm_q     <= '0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         p_out_v   <= 1'b0;
         p_out     <= '0;
         p_out_len <= '0;
      end else begin
         run_q <= 1'b1;
         if (emit) begin
            p_out     <= asm_d;
            p_out_len <= cnt_d;
            p_out_v   <= 1'b1;
            asm_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
         end else begin
            if (p_out_rdy)
               p_out_v <= 1'b0;
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
         end
      end
   end

endmodule

// File: tb/tb_sipo_pack.sv
// Directed bench for sipo_pack: packing, streaming, backpressure, flush and mid-burst reset.
module tb_sipo_pack;

   logic         clk;
   logic         rst_n;
   logic         s_in_v;
   logic [31:0]  s_in;
   logic         s_in_rdy;
   logic         flush;
   logic         p_out_v;
   logic [127:0] p_out;
   logic [2:0]   p_out_len;
   logic         p_out_rdy;

   int checks = 0;
   int errors = 0;

   sipo_pack #(.PE_NUM(4), .DATA_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_in_v    (s_in_v),
      .s_in      (s_in),
      .s_in_rdy  (s_in_rdy),
      .flush     (flush),
      .p_out_v   (p_out_v),
      .p_out     (p_out),
      .p_out_len (p_out_len),
      .p_out_rdy (p_out_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change and outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_in_v = 1'b0; s_in = '0; flush = 1'b0; p_out_rdy = 1'b1;
      #3;
      checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL reset_v got %b want 0", p_out_v); end
      checks++; if (p_out !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", p_out); end
      checks++; if (p_out_len !== 3'd0) begin errors++; $display("FAIL reset_len got %0d want 0", p_out_len); end
      checks++; if (s_in_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", s_in_rdy); end
      tick(); tick();
      #2 rst_n = 1'b1;
      #1;
      checks++; if (s_in_rdy !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got %b want 0", s_in_rdy); end
      tick();
      checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_edge got %b want 1", s_in_rdy); end
   endtask

   task automatic test_single_word();
      p_out_rdy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_in_v = 1'b1; s_in = 32'(i);
         tick();
         if (i < 4) begin
            checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL single_early_v word %0d got %b want 0", i, p_out_v); end
         end
      end
      s_in_v = 1'b0;
      checks++; if (p_out_v !== 1'b1) begin errors++; $display("FAIL single_v got %b want 1", p_out_v); end
      checks++; if (p_out !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL single_data got %h want 00000004000000030000000200000001", p_out); end
      checks++; if (p_out_len !== 3'd4) begin errors++; $display("FAIL single_len got %0d want 4", p_out_len); end
      tick();
      checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL single_v_drop got %b want 0", p_out_v); end
   endtask

   task automatic test_back_to_back();
      int nout;
      logic [127:0] last;
      nout = 0; last = '0;
      p_out_rdy = 1'b1;
      for (int i = 0; i < 32; i++) begin
         s_in_v = 1'b1; s_in = 32'(i + 1);
         checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy word %0d got %b want 1", i + 1, s_in_rdy); end
         tick();
         checks++; if (p_out_v !== ((i % 4) == 3)) begin errors++; $display("FAIL stream_v word %0d got %b want %b", i + 1, p_out_v, ((i % 4) == 3)); end
         if (p_out_v) begin nout++; last = p_out; end
      end
      s_in_v = 1'b0;
      checks++; if (nout !== 8) begin errors++; $display("FAIL stream_count got %0d want 8", nout); end
      checks++; if (last !== 128'h00000020_0000001f_0000001e_0000001d) begin errors++; $display("FAIL stream_last got %h want 000000200000001f0000001e0000001d", last); end
      tick();
   endtask

   task automatic test_backpressure();
      p_out_rdy = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         s_in_v = 1'b1; s_in = 32'(i);
         checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy word %0d got %b want 1", i, s_in_rdy); end
         tick();
      end
      s_in = 32'd9;
      checks++; if (s_in_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got %b want 0", s_in_rdy); end
      checks++; if (p_out !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL bp_hold got %h want 00000004000000030000000200000001", p_out); end
      tick();
      checks++; if (s_in_rdy !== 1'b0 || p_out_v !== 1'b1) begin errors++; $display("FAIL bp_stall rdy=%b v=%b want rdy=0 v=1", s_in_rdy, p_out_v); end
      checks++; if (p_out !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL bp_stable got %h want 00000004000000030000000200000001", p_out); end
      p_out_rdy = 1'b1;
      tick();
      p_out_rdy = 1'b0;
      checks++; if (p_out !== 128'h00000008_00000007_00000006_00000005) begin errors++; $display("FAIL bp_second got %h want 00000008000000070000000600000005", p_out); end
      checks++; if (p_out_v !== 1'b1 || p_out_len !== 3'd4) begin errors++; $display("FAIL bp_second_vl v=%b len=%0d want v=1 len=4", p_out_v, p_out_len); end
      checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_back got %b want 1", s_in_rdy); end
      tick();
      s_in_v = 1'b0;
      p_out_rdy = 1'b1;
      tick();
      checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", p_out_v); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL bp_flush_edge got %b want 0", p_out_v); end
      tick();
      checks++; if (p_out !== 128'h00000000_00000000_00000000_00000009 || p_out_len !== 3'd1) begin errors++; $display("FAIL bp_word9 got %h len %0d want 00000000000000000000000000000009 len 1", p_out, p_out_len); end
      tick();
   endtask

   task automatic test_flush();
      p_out_rdy = 1'b1;
      s_in_v = 1'b1; s_in = 32'hA; tick();
      s_in = 32'hB; tick();
      s_in_v = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL flush_same_edge got %b want 0", p_out_v); end
      tick();
      checks++; if (p_out_v !== 1'b1) begin errors++; $display("FAIL flush_v got %b want 1", p_out_v); end
      checks++; if (p_out !== 128'h00000000_00000000_0000000b_0000000a) begin errors++; $display("FAIL flush_data got %h want 00000000000000000000000b0000000a", p_out); end
      checks++; if (p_out_len !== 3'd2) begin errors++; $display("FAIL flush_len got %0d want 2", p_out_len); end
      tick();
   endtask

   task automatic test_flush_coincident();
      p_out_rdy = 1'b1;
      s_in_v = 1'b1; s_in = 32'hA; tick();
      s_in = 32'hB; tick();
      s_in = 32'hC; flush = 1'b1;
      tick();
      s_in_v = 1'b0; flush = 1'b0;
      checks++; if (s_in_rdy !== 1'b0 || p_out_v !== 1'b0) begin errors++; $display("FAIL coin_pend rdy=%b v=%b want rdy=0 v=0", s_in_rdy, p_out_v); end
      tick();
      checks++; if (p_out !== 128'h00000000_0000000c_0000000b_0000000a || p_out_len !== 3'd3) begin errors++; $display("FAIL coin_data got %h len %0d want 000000000000000c0000000b0000000a len 3", p_out, p_out_len); end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL empty_flush_a got %b want 0", p_out_v); end
      tick();
      checks++; if (p_out_v !== 1'b0 || s_in_rdy !== 1'b1) begin errors++; $display("FAIL empty_flush_b v=%b rdy=%b want v=0 rdy=1", p_out_v, s_in_rdy); end
   endtask

   task automatic test_reset_mid_burst();
      p_out_rdy = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         s_in_v = 1'b1; s_in = 32'(i + 16);
         tick();
      end
      s_in_v = 1'b0;
      checks++; if (p_out_v !== 1'b1) begin errors++; $display("FAIL mid_pre_v got %b want 1", p_out_v); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (p_out_v !== 1'b0 || p_out !== 128'h0 || p_out_len !== 3'd0 || s_in_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset v=%b data=%h len=%0d rdy=%b want all 0", p_out_v, p_out, p_out_len, s_in_rdy); end
      tick();
      #2 rst_n = 1'b1;
      tick();
      p_out_rdy = 1'b1;
      checks++; if (p_out_v !== 1'b0 || s_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_release v=%b rdy=%b want v=0 rdy=1", p_out_v, s_in_rdy); end
      for (int i = 1; i <= 4; i++) begin
         s_in_v = 1'b1; s_in = 32'(i + 32'h10);
         tick();
         if (i < 4) begin
            checks++; if (p_out_v !== 1'b0) begin errors++; $display("FAIL mid_early_v word %0d got %b want 0", i, p_out_v); end
         end
      end
      s_in_v = 1'b0;
      checks++; if (p_out !== 128'h00000014_00000013_00000012_00000011 || p_out_len !== 3'd4) begin errors++; $display("FAIL mid_fresh got %h len %0d want 00000014000000130000001200000011 len 4", p_out, p_out_len); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_flush_coincident();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
